fifo_rd_streamer: RTL and testbench
===================================

Name: fifo_rd_streamer

Overview:
Read-side engine for the sync FIFO primitive (e.g. the R36W36 mapping). It drives the FIFO read enable from the EMPTY flag and a credit counter, and absorbs the FIFO's fixed read latency in a small skid buffer. It presents the words as a valid/ready stream to downstream logic. It is the consumer-side counterpart to the FIFO write path and sustains 1 word/cycle while data is available and the sink is ready.

Parameters:
DATA_W, 36, FIFO/stream data width.
RD_LAT, 1, FIFO read latency in cycles from re to valid dout (1 or 2 supported).
SKID_DEPTH, RD_LAT+1, skid buffer entries; must be >= RD_LAT+1 for full throughput.

Ports:
clock0  in  1  single clock; all logic on posedge.
rst_n  in  1  asynchronous, active-low reset.
re  out  1  FIFO read enable.
dout  in  DATA_W  FIFO read data, valid RD_LAT cycles after re.
EMPTY  in  1  FIFO empty flag, registered; reflects all reads through the previous edge.
UNDERRUN  in  1  FIFO underrun flag.
m_data  out  DATA_W  stream data (buffer head).
m_valid  out  1  stream valid.
m_ready  in  1  stream ready from sink.
err_underrun  out  1  sticky: UNDERRUN seen while re was issued by this block.

Behaviour:
- Reset (rst_n=0, async): re=0, m_valid=0, m_data=0, err_underrun=0; inflight=0, buf_count=0, latency pipe cleared, wr/rd pointers=0. Takes effect immediately regardless of clock, including mid-burst. Words in flight are discarded; the FIFO pointer reset is owned externally.
- pop = m_valid & m_ready. Handshake rule: m_data/m_valid hold stable until pop.
- Credit: re = ~EMPTY & (inflight + buf_count - pop < SKID_DEPTH). re is combinational from registered state, EMPTY and m_ready. Back-to-back re is legal while EMPTY=0.
- Latency pipe: a RD_LAT-bit shift register of re. Bit RD_LAT-1 set means dout is captured into buffer[wr_ptr] at the next edge, and wr_ptr increments.
- inflight: +1 on re, -1 on capture, both in the same cycle -> unchanged. Range 0..RD_LAT.
- buf_count: +1 on capture, -1 on pop, both -> unchanged. Range 0..SKID_DEPTH; it never overflows by construction (assertion).
- Pointers are mod SKID_DEPTH and wrap from SKID_DEPTH-1 to 0.
- m_valid = (buf_count != 0). m_data = buffer[rd_ptr], or 0 when empty.
- Latency: first word reaches m_valid at RD_LAT+1 edges after the first re.
- EMPTY rising with reads in flight: those words are still captured and delivered; no new re is issued.
- Sink stalls (m_ready=0): re stops once credits are exhausted, so no word is lost. When the sink resumes, one word/cycle restarts with no bubble, because pop frees the credit in the same cycle.
- UNDERRUN=1 in any cycle where the latency pipe is non-zero sets err_underrun; it clears only on reset.

Optional Feature:
FIFO_RD_STAT_EN: when defined, adds output rd_count [31:0], which counts pops and wraps at 2^32-1 -> 0, plus input stat_clr, a synchronous clear (clear wins over an increment in the same cycle). When undefined, neither port nor counter exists, and the remaining behaviour is identical.

Decomposition:
- Shared package fifo_rd_pkg holds:
  - the RD_LAT_MAX=2 constant;
  - the credit-width function clog2(SKID_DEPTH+1);
  - the stream word typedef for DATA_W=36.
- One natural sub-module: fifo_rd_skid, the SKID_DEPTH-entry circular buffer with capture/pop/count. The top module keeps the credit logic and the latency pipe.

Test Plan:
- Prefill the FIFO with 1024 random 36-bit words, hold m_ready=1 -> re high for 1024 consecutive cycles, and 1024 pops in order matching the written words. First m_valid arrives 2 edges after the first re (RD_LAT=1).
- m_ready toggles 1/0 every cycle over 16 words -> no loss or duplication, re never leaves inflight+buf_count>2, and 16 words are delivered in order.
- m_ready=0 for 20 cycles with the FIFO non-empty -> exactly 2 re pulses, m_valid=1, m_data=first word held stable. m_ready then rises -> a pop every cycle with no bubble.
- FIFO holds 3 words; EMPTY goes high after the 3rd re -> exactly 3 pops, then m_valid=0 and re=0, and err_underrun stays 0.
- rst_n pulled low mid-burst between clock edges -> outputs go to 0 immediately. After release with the FIFO refilled with 0xA5A5A5A5A, the first pop returns 0xA5A5A5A5A.
- RD_LAT=2 with SKID_DEPTH=3, plus a forced UNDERRUN during in-flight reads -> sustained 1 word/cycle, err_underrun=1 sticky until reset. With FIFO_RD_STAT_EN defined, rd_count equals the number of pops.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared constants, stream word type and width helpers for the FIFO read streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_rd_pkg;

   // Deepest FIFO read latency the streamer's latency pipe is built for.
   localparam int RD_LAT_MAX = 2;

   // Native word width of the R36W36 FIFO mapping.
   localparam int WORD_W = 36;

   typedef logic [WORD_W-1:0] word_t;

   // Bits needed for a counter that must hold every value 0..depth inclusive.
   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed for a pointer that addresses depth entries (at least one bit).
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus valid/ready stream bundle; optional stats ports under FIFO_RD_STAT_EN.
// Latency: n/a (wiring only).
// Backpressure: m_ready from the sink; master = streamer, slave = FIFO + sink side.
interface fifo_rd_streamer_if #(
   parameter int DATA_W = 36
);
   // FIFO read side
   logic              re;
   logic [DATA_W-1:0] dout;
   logic              EMPTY;
   logic              UNDERRUN;
   // Stream side
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   // Status
   logic              err_underrun;
`ifdef FIFO_RD_STAT_EN
   logic [31:0]       rd_count;
   logic              stat_clr;

   modport master (
      output re, m_data, m_valid, err_underrun, rd_count,
      input  dout, EMPTY, UNDERRUN, m_ready, stat_clr
   );
   modport slave (
      input  re, m_data, m_valid, err_underrun, rd_count,
      output dout, EMPTY, UNDERRUN, m_ready, stat_clr
   );
`else
   modport master (
      output re, m_data, m_valid, err_underrun,
      input  dout, EMPTY, UNDERRUN, m_ready
   );
   modport slave (
      input  re, m_data, m_valid, err_underrun,
      output dout, EMPTY, UNDERRUN, m_ready
   );
`endif
endinterface

// File: rtl/fifo_rd_skid.sv
// Circular skid buffer that catches FIFO read data and presents the oldest word as the stream head.
// Latency: a captured word is visible at the head one edge after capture.
// Backpressure: none internally; the caller's credit logic guarantees a free entry for every capture.
module fifo_rd_skid
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W = WORD_W,
   parameter int DEPTH  = 2
) (
   input  logic                         clock0,
   input  logic                         rst_n,
   input  logic                         i_cap,
   input  logic [DATA_W-1:0]            i_cap_dat,
   input  logic                         i_pop,
   output logic [credit_w(DEPTH)-1:0]   o_count,
   output logic                         o_vld,
   output logic [DATA_W-1:0]            o_dat
);

   localparam int CW = credit_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_vld;

   // Pointers advance modulo DEPTH, so non power-of-two depths wrap explicitly.
   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage needs no reset: only entries below r_count are ever presented.
   always_ff @(posedge clock0) begin
      if (i_cap) begin
         r_mem[r_wr_ptr] <= i_cap_dat;
      end
   end

   // Write pointer follows captures, read pointer follows pops.
   always_ff @(posedge clock0 or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_cap) begin
            r_wr_ptr <= f_next(r_wr_ptr);
         end
         if (i_pop) begin
            r_rd_ptr <= f_next(r_rd_ptr);
         end
      end
   end

   // Occupancy: capture and pop in the same cycle cancel out.
   always_ff @(posedge clock0 or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         case ({i_cap, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_vld   = (r_count != '0);
   assign o_vld   = w_vld;
   assign o_count = r_count;
   // Head reads as zero while empty so the stream bus is quiet between bursts.
   assign o_dat   = w_vld ? r_mem[r_rd_ptr] : '0;

   // The upstream credit check must never let a capture land in a full buffer.
   a_no_overflow: assert property (@(posedge clock0) disable iff (!rst_n)
      !(i_cap && !i_pop && (r_count == CW'(DEPTH))));

   // A pop is only legal while the head is valid.
   a_no_underflow: assert property (@(posedge clock0) disable iff (!rst_n)
      !(i_pop && !w_vld));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read engine for the sync FIFO: credit-gated re, latency pipe, skid buffer, valid/ready stream out.
// Latency: first word valid RD_LAT+1 edges after the first re; sustains 1 word/cycle.
// Backpressure: re stops once inflight+buffered words fill SKID_DEPTH; optional stats under FIFO_RD_STAT_EN.
module fifo_rd_streamer
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W     = WORD_W,
   parameter int RD_LAT     = 1,
   parameter int SKID_DEPTH = RD_LAT + 1
) (
   input  logic               clock0,
   input  logic               rst_n,
   fifo_rd_streamer_if.master bus
);

   localparam int CW = credit_w(SKID_DEPTH);

   if ((RD_LAT < 1) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_lat
      $error("fifo_rd_streamer: RD_LAT must be 1..%0d", RD_LAT_MAX);
   end
   if (SKID_DEPTH < 1) begin : g_bad_depth
      $error("fifo_rd_streamer: SKID_DEPTH must be at least 1");
   end

   logic [RD_LAT-1:0] r_lat;
   logic [CW-1:0]     r_inflight;
   logic              r_err_underrun;
   logic [CW-1:0]     w_buf_count;
   logic [CW:0]       w_occ;
   logic              w_m_valid;
   logic              w_pop;
   logic              w_cap;
   logic              w_re;

   assign w_pop = w_m_valid & bus.m_ready;
   assign w_cap = r_lat[RD_LAT-1];

   // Words already committed after this cycle's pop; a pop frees its credit in the same
   // cycle, which is what keeps the stream bubble-free when the sink resumes.
   assign w_occ = {1'b0, r_inflight} + {1'b0, w_buf_count} - {{CW{1'b0}}, w_pop};

   // Gating with rst_n keeps re low while held in reset even if EMPTY is still low.
   assign w_re  = rst_n & ~bus.EMPTY & (w_occ < (CW+1)'(SKID_DEPTH));

   // Latency pipe: one bit per outstanding read cycle, the top bit marks dout valid now.
   always_ff @(posedge clock0 or negedge rst_n) begin
      if (!rst_n) begin
         r_lat <= '0;
      end else begin
         r_lat <= (r_lat << 1) | RD_LAT'(w_re);
      end
   end

   // Reads issued but not yet captured into the skid buffer.
   always_ff @(posedge clock0 or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= '0;
      end else begin
         case ({w_re, w_cap})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Sticky underrun flag: only counts while our own reads are in the pipe.
   always_ff @(posedge clock0 or negedge rst_n) begin
      if (!rst_n) begin
         r_err_underrun <= 1'b0;
      end else if (bus.UNDERRUN && (r_lat != '0)) begin
         r_err_underrun <= 1'b1;
      end
   end

   fifo_rd_skid #(
      .DATA_W (DATA_W),
      .DEPTH  (SKID_DEPTH)
   ) u_skid (
      .clock0    (clock0),
      .rst_n     (rst_n),
      .i_cap     (w_cap),
      .i_cap_dat (bus.dout),
      .i_pop     (w_pop),
      .o_count   (w_buf_count),
      .o_vld     (w_m_valid),
      .o_dat     (bus.m_data)
   );

   assign bus.re           = w_re;
   assign bus.m_valid      = w_m_valid;
   assign bus.err_underrun = r_err_underrun;

`ifdef FIFO_RD_STAT_EN
   logic [31:0] r_rd_count;

   // Pop counter; a clear in the same cycle as a pop wins, wrap at 2^32 is natural.
   always_ff @(posedge clock0 or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_count <= '0;
      end else if (bus.stat_clr) begin
         r_rd_count <= '0;
      end else if (w_pop) begin
         r_rd_count <= r_rd_count + 32'd1;
      end
   end

   assign bus.rd_count = r_rd_count;
`endif

   // Reads in flight can never exceed the FIFO read latency.
   a_inflight_bound: assert property (@(posedge clock0) disable iff (!rst_n)
      r_inflight <= CW'(RD_LAT));

   // The FIFO is never read while it reports empty.
   a_no_read_empty: assert property (@(posedge clock0) disable iff (!rst_n)
      !(w_re && bus.EMPTY));

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: RD_LAT=1/SKID=2 instance (a) and RD_LAT=2/SKID=3 instance (b).
// Latency: behavioural FIFO models honour each instance's read latency and registered EMPTY.
// Backpressure: bench drives m_ready patterns; stats checks only when FIFO_RD_STAT_EN is defined.
module tb_fifo_rd_streamer;
   import fifo_rd_pkg::*;

   localparam int DW = 36;

   logic clk;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fifo_rd_streamer_if #(.DATA_W(DW)) ifa ();
   fifo_rd_streamer_if #(.DATA_W(DW)) ifb ();

   fifo_rd_streamer #(.DATA_W(DW), .RD_LAT(1), .SKID_DEPTH(2)) dut_a (
      .clock0 (clk),
      .rst_n  (rst_n),
      .bus    (ifa.master)
   );

   fifo_rd_streamer #(.DATA_W(DW), .RD_LAT(2), .SKID_DEPTH(3)) dut_b (
      .clock0 (clk),
      .rst_n  (rst_n),
      .bus    (ifb.master)
   );

   // FIFO models: bench owns write pointers, models own read pointers.
   word_t mem_a [4096];
   word_t mem_b [4096];
   int    wp_a = 0;
   int    wp_b = 0;
   int    rp_a;
   int    rp_b;
   int    rd_a = 0;
   int    rd_b = 0;
   word_t pipe_b;

   // RD_LAT=1 FIFO: dout valid the cycle after re, EMPTY registered.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rp_a      <= wp_a;
         ifa.dout  <= '0;
         ifa.EMPTY <= 1'b1;
      end else begin
         if (ifa.re) ifa.dout <= mem_a[12'(rp_a)];
         rp_a      <= rp_a + (ifa.re ? 1 : 0);
         ifa.EMPTY <= ((rp_a + (ifa.re ? 1 : 0)) == wp_a);
      end
   end

   // RD_LAT=2 FIFO: one extra register stage on the read data.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rp_b      <= wp_b;
         pipe_b    <= '0;
         ifb.dout  <= '0;
         ifb.EMPTY <= 1'b1;
      end else begin
         if (ifb.re) pipe_b <= mem_b[12'(rp_b)];
         ifb.dout  <= pipe_b;
         rp_b      <= rp_b + (ifb.re ? 1 : 0);
         ifb.EMPTY <= ((rp_b + (ifb.re ? 1 : 0)) == wp_b);
      end
   end

   task automatic push_a(input word_t w);
      mem_a[12'(wp_a)] = w;
      wp_a = wp_a + 1;
   endtask

   task automatic push_b(input word_t w);
      mem_b[12'(wp_b)] = w;
      wp_b = wp_b + 1;
   endtask

   function automatic word_t rnd_word();
      return {4'($urandom_range(15)), 32'($urandom())};
   endfunction

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      n_chk++; if (ifa.re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b want 0", ifa.re); end
      n_chk++; if (ifa.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", ifa.m_valid); end
      n_chk++; if (ifa.m_data !== 36'h0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0", ifa.m_data); end
      n_chk++; if (ifa.err_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", ifa.err_underrun); end
      n_chk++; if (ifb.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_m_valid: got %b want 0", ifb.m_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_chk++; if (ifa.re !== 1'b0) begin n_fail++; $display("FAIL idle_re: got %b want 0", ifa.re); end
   endtask

   task automatic test_stream();
      int first_re, first_vld, re_cnt, pops, streak, max_streak, cyc;
      first_re = -1; first_vld = -1; re_cnt = 0; pops = 0; streak = 0; max_streak = 0;
      for (int i = 0; i < 1024; i++) push_a(rnd_word());
      ifa.m_ready = 1'b1;
      for (cyc = 0; cyc < 1200 && pops < 1024; cyc++) begin
         @(negedge clk); #1;
         if (ifa.re) begin
            re_cnt++;
            if (first_re < 0) first_re = cyc;
            streak++;
            if (streak > max_streak) max_streak = streak;
         end else begin
            streak = 0;
         end
         if (ifa.m_valid && ifa.m_ready) begin
            if (first_vld < 0) first_vld = cyc;
            n_chk++;
            if (ifa.m_data !== mem_a[12'(rd_a)]) begin
               n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", pops, ifa.m_data, mem_a[12'(rd_a)]);
            end
            rd_a++; pops++;
         end
      end
      n_chk++; if (pops != 1024) begin n_fail++; $display("FAIL stream_pops: got %0d want 1024", pops); end
      n_chk++; if (re_cnt != 1024) begin n_fail++; $display("FAIL stream_re_count: got %0d want 1024", re_cnt); end
      n_chk++; if (max_streak != 1024) begin n_fail++; $display("FAIL stream_re_streak: got %0d want 1024", max_streak); end
      n_chk++; if (first_vld - first_re != 2) begin n_fail++; $display("FAIL stream_latency: got %0d want 2", first_vld - first_re); end
      @(negedge clk); #1;
      n_chk++; if (ifa.m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained_valid: got %b want 0", ifa.m_valid); end
      n_chk++; if (ifa.re !== 1'b0) begin n_fail++; $display("FAIL stream_drained_re: got %b want 0", ifa.re); end
   endtask

   task automatic test_toggle();
      int pops, occ, max_occ, cyc;
      logic pop;
      pops = 0; occ = 0; max_occ = 0;
      for (int i = 0; i < 16; i++) push_a(rnd_word());
      for (cyc = 0; cyc < 100 && pops < 16; cyc++) begin
         @(negedge clk);
         ifa.m_ready = ((cyc % 2) == 1);
         #1;
         pop = ifa.m_valid & ifa.m_ready;
         if (pop) begin
            n_chk++;
            if (ifa.m_data !== mem_a[12'(rd_a)]) begin
               n_fail++; $display("FAIL toggle_data[%0d]: got %h want %h", pops, ifa.m_data, mem_a[12'(rd_a)]);
            end
            rd_a++; pops++;
         end
         occ = occ + (ifa.re ? 1 : 0) - (pop ? 1 : 0);
         if (occ > max_occ) max_occ = occ;
      end
      n_chk++; if (pops != 16) begin n_fail++; $display("FAIL toggle_pops: got %0d want 16", pops); end
      n_chk++; if (max_occ != 2) begin n_fail++; $display("FAIL toggle_max_occupancy: got %0d want 2", max_occ); end
      @(negedge clk); ifa.m_ready = 1'b1; #1;
      n_chk++; if (ifa.m_valid !== 1'b0) begin n_fail++; $display("FAIL toggle_drained: got %b want 0", ifa.m_valid); end
   endtask

   task automatic test_stall();
      int re_cnt, held_bad, bubble, pops;
      word_t first_word;
      re_cnt = 0; held_bad = 0; bubble = 0; pops = 0;
      for (int i = 0; i < 6; i++) push_a(rnd_word());
      first_word = mem_a[12'(rd_a)];
      ifa.m_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (ifa.re) re_cnt++;
         if (ifa.m_valid && (ifa.m_data !== first_word)) held_bad++;
      end
      n_chk++; if (re_cnt != 2) begin n_fail++; $display("FAIL stall_re_pulses: got %0d want 2", re_cnt); end
      n_chk++; if (ifa.m_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", ifa.m_valid); end
      n_chk++; if (ifa.m_data !== first_word) begin n_fail++; $display("FAIL stall_head: got %h want %h", ifa.m_data, first_word); end
      n_chk++; if (held_bad != 0) begin n_fail++; $display("FAIL stall_head_stable: got %0d changes want 0", held_bad); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); ifa.m_ready = 1'b1; #1;
         if (!ifa.m_valid) begin
            bubble++;
         end else begin
            n_chk++;
            if (ifa.m_data !== mem_a[12'(rd_a)]) begin
               n_fail++; $display("FAIL stall_resume_data[%0d]: got %h want %h", pops, ifa.m_data, mem_a[12'(rd_a)]);
            end
            rd_a++; pops++;
         end
      end
      n_chk++; if (bubble != 0) begin n_fail++; $display("FAIL stall_resume_bubbles: got %0d want 0", bubble); end
      @(negedge clk); #1;
      n_chk++; if (ifa.m_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained: got %b want 0", ifa.m_valid); end
   endtask

   task automatic test_empty_inflight();
      int re_cnt, pops;
      re_cnt = 0; pops = 0;
      for (int i = 0; i < 3; i++) push_a(rnd_word());
      ifa.m_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (ifa.re) re_cnt++;
         if (ifa.m_valid) begin
            n_chk++;
            if (ifa.m_data !== mem_a[12'(rd_a)]) begin
               n_fail++; $display("FAIL empty_data[%0d]: got %h want %h", pops, ifa.m_data, mem_a[12'(rd_a)]);
            end
            rd_a++; pops++;
         end
      end
      n_chk++; if (re_cnt != 3) begin n_fail++; $display("FAIL empty_re_count: got %0d want 3", re_cnt); end
      n_chk++; if (pops != 3) begin n_fail++; $display("FAIL empty_pops: got %0d want 3", pops); end
      n_chk++; if (ifa.m_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid_end: got %b want 0", ifa.m_valid); end
      n_chk++; if (ifa.re !== 1'b0) begin n_fail++; $display("FAIL empty_re_end: got %b want 0", ifa.re); end
      n_chk++; if (ifa.err_underrun !== 1'b0) begin n_fail++; $display("FAIL empty_err: got %b want 0", ifa.err_underrun); end
   endtask

   task automatic test_reset_mid();
      int got;
      got = 0;
      for (int i = 0; i < 8; i++) push_a(rnd_word());
      ifa.m_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         if (ifa.m_valid) rd_a++;
      end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (ifa.re !== 1'b0) begin n_fail++; $display("FAIL midrst_re: got %b want 0", ifa.re); end
      n_chk++; if (ifa.m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", ifa.m_valid); end
      n_chk++; if (ifa.m_data !== 36'h0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", ifa.m_data); end
      @(negedge clk);
      rst_n = 1'b1;
      rd_a = wp_a;
      push_a(36'hA5A5A5A5A);
      for (int c = 0; c < 10 && got == 0; c++) begin
         @(negedge clk); #1;
         if (ifa.m_valid) begin
            got = 1;
            n_chk++;
            if (ifa.m_data !== 36'hA5A5A5A5A) begin
               n_fail++; $display("FAIL midrst_first_pop: got %h want a5a5a5a5a", ifa.m_data);
            end
            rd_a++;
         end
      end
      n_chk++; if (got != 1) begin n_fail++; $display("FAIL midrst_timeout: got %0d pops want 1", got); end
      @(negedge clk); #1;
      n_chk++; if (ifa.m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_stale: got %b want 0", ifa.m_valid); end
   endtask

   task automatic test_stat();
`ifdef FIFO_RD_STAT_EN
      n_chk++; if (ifa.rd_count !== 32'd1) begin n_fail++; $display("FAIL stat_count: got %0d want 1", ifa.rd_count); end
      push_a(rnd_word());
      push_a(rnd_word());
      ifa.m_ready = 1'b0;
      repeat (5) @(negedge clk);
      ifa.m_ready = 1'b1;
      ifa.stat_clr = 1'b1;
      @(negedge clk);
      ifa.stat_clr = 1'b0;
      ifa.m_ready = 1'b0;
      rd_a++;
      #1;
      n_chk++; if (ifa.rd_count !== 32'd0) begin n_fail++; $display("FAIL stat_clear_wins: got %0d want 0", ifa.rd_count); end
      @(negedge clk);
      ifa.m_ready = 1'b1;
      @(negedge clk); #1;
      rd_a++;
      n_chk++; if (ifa.rd_count !== 32'd1) begin n_fail++; $display("FAIL stat_after_clear: got %0d want 1", ifa.rd_count); end
`endif
   endtask

   task automatic test_lat2();
      int first_re, first_vld, last_pop, pops, cyc;
      first_re = -1; first_vld = -1; last_pop = -1; pops = 0;
      // UNDERRUN with nothing in flight must not raise the flag.
      @(negedge clk); ifb.UNDERRUN = 1'b1;
      @(negedge clk); ifb.UNDERRUN = 1'b0; #1;
      n_chk++; if (ifb.err_underrun !== 1'b0) begin n_fail++; $display("FAIL lat2_idle_underrun: got %b want 0", ifb.err_underrun); end
      for (int i = 0; i < 12; i++) push_b(rnd_word());
      ifb.m_ready = 1'b1;
      for (cyc = 0; cyc < 60 && pops < 12; cyc++) begin
         @(negedge clk);
         ifb.UNDERRUN = (first_re >= 0) && (cyc == first_re + 1);
         #1;
         if (ifb.re && first_re < 0) first_re = cyc;
         if (ifb.m_valid) begin
            if (first_vld < 0) first_vld = cyc;
            last_pop = cyc;
            n_chk++;
            if (ifb.m_data !== mem_b[12'(rd_b)]) begin
               n_fail++; $display("FAIL lat2_data[%0d]: got %h want %h", pops, ifb.m_data, mem_b[12'(rd_b)]);
            end
            rd_b++; pops++;
         end
      end
      ifb.UNDERRUN = 1'b0;
      n_chk++; if (pops != 12) begin n_fail++; $display("FAIL lat2_pops: got %0d want 12", pops); end
      n_chk++; if (first_vld - first_re != 3) begin n_fail++; $display("FAIL lat2_latency: got %0d want 3", first_vld - first_re); end
      n_chk++; if (last_pop - first_vld != 11) begin n_fail++; $display("FAIL lat2_throughput: got %0d want 11", last_pop - first_vld); end
      n_chk++; if (ifb.err_underrun !== 1'b1) begin n_fail++; $display("FAIL lat2_err_set: got %b want 1", ifb.err_underrun); end
      repeat (5) @(negedge clk);
      #1;
      n_chk++; if (ifb.err_underrun !== 1'b1) begin n_fail++; $display("FAIL lat2_err_sticky: got %b want 1", ifb.err_underrun); end
      n_chk++; if (ifb.m_valid !== 1'b0) begin n_fail++; $display("FAIL lat2_drained: got %b want 0", ifb.m_valid); end
      n_chk++; if (ifa.err_underrun !== 1'b0) begin n_fail++; $display("FAIL lat2_a_err: got %b want 0", ifa.err_underrun); end
`ifdef FIFO_RD_STAT_EN
      n_chk++; if (ifb.rd_count !== 32'd12) begin n_fail++; $display("FAIL lat2_rd_count: got %0d want 12", ifb.rd_count); end
`endif
   endtask

   task automatic test_final_reset();
      @(negedge clk); #2 rst_n = 1'b0; #1;
      n_chk++; if (ifb.err_underrun !== 1'b0) begin n_fail++; $display("FAIL final_reset_err: got %b want 0", ifb.err_underrun); end
      @(negedge clk); rst_n = 1'b1;
      rd_a = wp_a;
      rd_b = wp_b;
   endtask

   initial begin
      ifa.m_ready  = 1'b1;
      ifa.UNDERRUN = 1'b0;
      ifb.m_ready  = 1'b1;
      ifb.UNDERRUN = 1'b0;
`ifdef FIFO_RD_STAT_EN
      ifa.stat_clr = 1'b0;
      ifb.stat_clr = 1'b0;
`endif
      test_reset();
      test_stream();
      test_toggle();
      test_stall();
      test_empty_inflight();
      test_reset_mid();
      test_stat();
      test_lat2();
      test_final_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
